// File: rtl/row_request_encoder.sv
// ============================================================================
// row_request_encoder
//
// Registered request encoder. This is the inverse of the row address decoder.
// Row clients raise level requests on `req`. The encoder picks one winner and
// presents it as a binary address (`adr`) plus a `select` strobe, which the
// decoder expands back into a one-hot `sel_x`. A one-hot copy of the winner is
// also driven on `grant`. A grant stays frozen until the consumer raises `ack`.
//
// Build option:
//   ROW_ENC_ROUND_ROBIN_EN defined   : round-robin search starting at a
//                                      pointer that advances past each
//                                      acknowledged row.
//   ROW_ENC_ROUND_ROBIN_EN undefined : fixed priority, where the lowest set
//                                      request index wins.
//
// Parameters:
//   N  - number of request lines (power of two)
//   AW - address width, log2(N)
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous active-high reset
//   req     in   N   per-row level requests
//   ack     in   1   consumer accepted current grant (used only while select=1)
//   adr     out  AW  encoded address of granted row (holds last value in IDLE)
//   select  out  1   grant valid strobe
//   grant   out  N   one-hot granted row, zero when select=0
//   pending out  1   registered OR of req
//
// Every output comes straight from a flop. No input reaches an output
// combinationally, so the decoder never sees glitches.
// ============================================================================
module row_request_encoder #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          ack,
    output logic [AW-1:0] adr,
    output logic          select,
    output logic [N-1:0]  grant,
    output logic          pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            select_q, select_d;
    logic            pending_q;

    logic [AW-1:0]   winner;
    logic            anyReq;

    // A single set bit, shifted into position to build the one-hot grant.
    localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};

    assign anyReq = |req;

`ifdef ROW_ENC_ROUND_ROBIN_EN
    // Search pointer. It points one row past the last acknowledged grant.
    logic [AW-1:0] ptr_q, ptr_d;

    // Round-robin winner search. The scan starts at ptr_q and wraps.
    // Because N == 2**AW, the AW-bit sum wraps modulo N by itself.
    // The loop runs from the farthest offset down to offset 0. That way the
    // nearest set bit from ptr_q is the last assignment, and it wins.
    always_comb begin
        logic [AW-1:0] idx;
        winner = '0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr_q + AW'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end
`else
    // Fixed-priority winner search: the lowest set index wins. The loop runs
    // downward, so the smallest index is the last assignment.
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = AW'(k);
            end
        end
    end
`endif

    // Next-state logic.
    // IDLE captures a winner as soon as any request is present.
    // GRANT freezes adr/grant until ack, then releases back to IDLE. This
    // forces select low for exactly one cycle between back-to-back grants.
    // ack is not examined in IDLE, so an ack held high cannot pre-acknowledge
    // the next grant.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        grant_d  = grant_q;
        select_d = select_q;
`ifdef ROW_ENC_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    adr_d    = winner;
                    grant_d  = ONE_HOT_BASE << winner;
                    select_d = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    select_d = 1'b0;
                    grant_d  = '0;
                    state_d  = IDLE;
`ifdef ROW_ENC_ROUND_ROBIN_EN
                    // Advance past the served row. The AW-bit add wraps N-1 to 0.
                    ptr_d    = adr_q + AW'(1);
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                select_d = 1'b0;
                grant_d  = '0;
            end
        endcase
    end

    // State and output registers.
    // Reset takes priority over everything, including an active grant and any
    // request present in the same cycle. pending tracks req every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            grant_q   <= '0;
            select_q  <= 1'b0;
            pending_q <= 1'b0;
`ifdef ROW_ENC_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            pending_q <= anyReq;
`ifdef ROW_ENC_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign adr     = adr_q;
    assign select  = select_q;
    assign grant   = grant_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_row_request_encoder.sv
// ============================================================================
// tb_row_request_encoder
//
// Directed testbench for row_request_encoder with N=8 and AW=3.
// The stimulus process pushes the hand-computed grant it expects (address plus
// one-hot) into a queue before the edge that should produce it. A monitor
// thread pops the queue and compares each time select rises. The stimulus
// process also checks cycle-level state: select, adr, grant and pending.
// Expectations for the wrap test follow ROW_ENC_ROUND_ROBIN_EN.
// ============================================================================
module tb_row_request_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [2:0] adr;
    logic       select;
    logic [7:0] grant;
    logic       pending;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct packed {
        logic [2:0] adr;
        logic [7:0] grant;
    } exp_t;

    exp_t expQ[$];

    row_request_encoder #(.N(8), .AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .adr     (adr),
        .select  (select),
        .grant   (grant),
        .pending (pending)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then advance one rising edge and settle 1 ns past it.
    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic a);
        rst = r;
        req = rq;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pushExpected(input logic [2:0] a, input logic [7:0] g);
        exp_t e;
        e.adr   = a;
        e.grant = g;
        expQ.push_back(e);
    endtask

    initial begin
        logic [2:0] wrapExp [5];

`ifdef ROW_ENC_ROUND_ROBIN_EN
        wrapExp = '{3'd0, 3'd1, 3'd7, 3'd0, 3'd1};
`else
        wrapExp = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif

        rst = 1'b1;
        req = 8'h00;
        ack = 1'b0;

        // Scoreboard monitor: on every rising select, pop and compare.
        fork
            begin : monitor
                logic prevSel;
                exp_t e;
                prevSel = 1'b0;
                forever begin
                    @(negedge clk);
                    if (select === 1'b1 && prevSel !== 1'b1) begin
                        if (expQ.size() == 0) begin
                            testsRun++;
                            testsFailed++;
                            $display("[TB] FAIL sb_unexpected_grant: got adr=%0d grant=%0h, expected no grant at %0t",
                                     adr, grant, $time);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("sb_adr", 32'(adr), 32'(e.adr));
                            checkOutput("sb_grant", 32'(grant), 32'(e.grant));
                        end
                    end
                    prevSel = select;
                end
            end
        join_none

        // Reset state.
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("rst_select", 32'(select), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_adr", 32'(adr), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);

        // A request present during reset is not granted.
        applyStimulus(1'b1, 8'h10, 1'b0);
        checkOutput("rst_req_select", 32'(select), 32'd0);
        checkOutput("rst_req_pending", 32'(pending), 32'd0);

        // Reset mid-grant.
        pushExpected(3'd4, 8'h10);
        applyStimulus(1'b0, 8'h10, 1'b0);
        checkOutput("mid_grant_select", 32'(select), 32'd1);
        checkOutput("mid_grant_adr", 32'(adr), 32'd4);
        checkOutput("mid_grant_pending", 32'(pending), 32'd1);
        applyStimulus(1'b1, 8'h10, 1'b0);
        checkOutput("mid_rst_select", 32'(select), 32'd0);
        checkOutput("mid_rst_grant", 32'(grant), 32'd0);
        checkOutput("mid_rst_adr", 32'(adr), 32'd0);
        pushExpected(3'd4, 8'h10);
        applyStimulus(1'b0, 8'h10, 1'b0);
        checkOutput("regrant_select", 32'(select), 32'd1);
        checkOutput("regrant_adr", 32'(adr), 32'd4);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("regrant_release", 32'(select), 32'd0);
        checkOutput("release_adr_held", 32'(adr), 32'd4);

        // Single request.
        pushExpected(3'd5, 8'h20);
        applyStimulus(1'b0, 8'h20, 1'b0);
        checkOutput("single_select", 32'(select), 32'd1);
        checkOutput("single_adr", 32'(adr), 32'd5);
        checkOutput("single_grant", 32'(grant), 32'h20);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("single_release", 32'(select), 32'd0);
        checkOutput("single_release_grant", 32'(grant), 32'd0);

        // Hold under request change.
        pushExpected(3'd2, 8'h04);
        applyStimulus(1'b0, 8'h04, 1'b0);
        checkOutput("hold_select", 32'(select), 32'd1);
        checkOutput("hold_adr", 32'(adr), 32'd2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h80, 1'b0);
            checkOutput("hold_adr_frozen", 32'(adr), 32'd2);
            checkOutput("hold_grant_frozen", 32'(grant), 32'h04);
            checkOutput("hold_select_frozen", 32'(select), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("hold_release", 32'(select), 32'd0);
        checkOutput("hold_pending_low", 32'(pending), 32'd0);

        // Round-robin wrap / fixed priority with req=1000_0011 held.
        applyStimulus(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pushExpected(wrapExp[i], 8'h01 << wrapExp[i]);
            applyStimulus(1'b0, 8'h83, 1'b0);
            checkOutput("wrap_select", 32'(select), 32'd1);
            checkOutput("wrap_adr", 32'(adr), 32'(wrapExp[i]));
            applyStimulus(1'b0, 8'h83, 1'b1);
            checkOutput("wrap_gap", 32'(select), 32'd0);
        end

        // Ack held high through IDLE.
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ack_idle_select", 32'(select), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ack_idle_select2", 32'(select), 32'd0);
        pushExpected(3'd3, 8'h08);
        applyStimulus(1'b0, 8'h08, 1'b1);
        checkOutput("ack_idle_grant", 32'(select), 32'd1);
        checkOutput("ack_idle_adr", 32'(adr), 32'd3);
        applyStimulus(1'b0, 8'h08, 1'b1);
        checkOutput("ack_idle_release", 32'(select), 32'd0);
        pushExpected(3'd3, 8'h08);
        applyStimulus(1'b0, 8'h08, 1'b1);
        checkOutput("ack_idle_regrant", 32'(select), 32'd1);
        checkOutput("ack_idle_regrant_adr", 32'(adr), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ack_idle_final_release", 32'(select), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Every expected grant must have been observed.
        checkOutput("sb_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
